// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: FSM state codes, default baud divisor, frame length.
// Frame length depends on the UART_TX_PARITY_EN macro (8E1 when defined, 8N1 otherwise).
package uart_pkg;

  localparam int unsigned CLKDIV_DEFAULT = 104;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  function automatic int unsigned frame_cycles(input int unsigned clkdiv);
    return FRAME_BITS * clkdiv;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte stream into the UART transmitter: valid/ready handshake with an 8-bit payload.
interface uart_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO, power-of-two depth; extra pointer MSB tells full from empty.
module uart_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed, LSB-first, CLKDIV clocks per bit, registered ser_tx.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit after the data); default is 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter  int unsigned CLKDIV     = CLKDIV_DEFAULT,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  uart_tx_if.slave      in_if,
  output logic          ser_tx,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam logic [15:0] BAUD_LOAD = 16'(CLKDIV - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ser_tx_q, ser_tx_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        fifo_full, fifo_empty, fifo_pop, start_frame, baud_tick;
  logic [7:0]  fifo_data;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (in_if.in_valid),
    .push_data (in_if.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign in_if.in_ready = !fifo_full;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;
  assign ser_tx         = ser_tx_q;
  assign baud_tick      = (baud_q == 16'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ser_tx_d    = ser_tx_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      ST_IDLE: start_frame = !fifo_empty;
      ST_START: begin
        if (baud_tick) begin
          state_d  = ST_DATA;
          ser_tx_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
          baud_d   = BAUD_LOAD;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          baud_d = BAUD_LOAD;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = ST_PARITY;
            ser_tx_d = par_q;
`else
            state_d  = ST_STOP;
            ser_tx_d = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            ser_tx_d  = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d  = ST_STOP;
          ser_tx_d = 1'b1;
          baud_d   = BAUD_LOAD;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          // Chain straight into the next start bit so queued frames run without a gap.
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ser_tx_d = 1'b1;
      end
    endcase

    if (start_frame) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_data;
      state_d   = ST_START;
      ser_tx_d  = 1'b0;
      baud_d    = BAUD_LOAD;
      bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_d     = ^fifo_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ser_tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ser_tx_q  <= ser_tx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level line model compared every cycle, a mid-bit UART decoder,
// and hand-computed literal checks for reset, single frames, burst, mid-frame reset and wrap.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLKDIV    = 104;
  localparam int DEPTH     = 16;
  localparam int FRAME_CYC = int'(frame_cycles(CLKDIV));

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ser_tx, busy;
  logic [4:0] fifo_level;

  uart_tx_if u_if();

  uart_tx #(.CLKDIV(CLKDIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_if      (u_if),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: queue of bytes + current frame position ----------------
  logic [7:0] mq[$];
  logic [7:0] m_cur = '0;
  bit         m_active = 0;
  int         m_t = 0;

  function automatic logic line_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      mq.delete();
      m_active = 0;
      m_t      = 0;
    end else begin
      bit         push;
      logic [7:0] pd;
      push = u_if.in_valid && (mq.size() < DEPTH);
      pd   = u_if.in_data;
      if (m_active) begin
        m_t++;
        if (m_t == FRAME_CYC) m_active = 0;
      end
      if (!m_active && mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1;
        m_t      = 0;
      end
      if (push) mq.push_back(pd);
    end
  end

  initial forever begin
    @(negedge clk);
    check("line", ser_tx, m_active ? line_bit(m_cur, m_t / CLKDIV) : 1'b1);
    check("busy", busy, (m_active || mq.size() != 0) ? 1 : 0);
    check("fifo_level", fifo_level, mq.size());
    check("in_ready", u_if.in_ready, (mq.size() < DEPTH) ? 1 : 0);
  end

  // ---------------- mid-bit decoder ----------------
  logic [7:0] dec_q[$];
  logic [7:0] sent_q[$];
  int rst_cnt = 0;

  initial forever begin
    @(negedge resetn);
    rst_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (resetn && ser_tx === 1'b0) begin
      int         snap;
      logic [7:0] b;
      bit         ok;
      snap = rst_cnt;
      repeat (CLKDIV / 2) @(negedge clk);
      ok = (ser_tx == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CLKDIV) @(negedge clk);
        b[i] = ser_tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CLKDIV) @(negedge clk);
      ok = ok && (ser_tx == ^b);
`endif
      repeat (CLKDIV) @(negedge clk);
      ok = ok && (ser_tx == 1'b1);
      if (snap == rst_cnt) begin
        check("decoder_framing", ok, 1);
        if (ok) dec_q.push_back(b);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    bit acc = 0;
    int guard = 0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    while (!acc && guard < 4 * FRAME_CYC) begin
      @(posedge clk);
      acc = u_if.in_ready;
      @(negedge clk);
      guard++;
    end
    u_if.in_valid = 1'b0;
    check("send_accepted", acc, 1);
    if (acc) sent_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_in_budget", busy, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_dec(input string name);
    check({name, "_count"}, dec_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < dec_q.size(); i++)
      check({name, "_byte"}, dec_q[i], sent_q[i]);
    dec_q.delete();
    sent_q.delete();
  endtask

  // From idle: push one byte, then walk the frame checking mid-bit levels against a literal.
  task automatic frame_literal(input string name, input logic [7:0] b, input logic [10:0] lit);
    send(b);
    check({name, "_queued"}, fifo_level, 1);
    check({name, "_line_before_start"}, ser_tx, 1);
    @(posedge clk); #1;
    for (int c = 0; c <= FRAME_CYC; c++) begin
      if (c % CLKDIV == CLKDIV / 2 && c < FRAME_CYC)
        check({name, "_bit"}, ser_tx, lit[c / CLKDIV]);
      if (c == FRAME_CYC - 1) check({name, "_busy_last"}, busy, 1);
      if (c == FRAME_CYC) begin
        check({name, "_busy_end"}, busy, 0);
        check({name, "_line_end"}, ser_tx, 1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    compare_dec(name);
  endtask

  initial begin
    int idx;
    int guard;
    int max_level;
    bit acc;

    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;

    // 1: reset
    #23;
    check("rst_ser_tx", ser_tx, 1);
    check("rst_in_ready", u_if.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_ser_tx", ser_tx, 1);
    check("post_rst_busy", busy, 0);

    // 2: single 0x55 (start, 1,0,1,0,1,0,1,0, [parity 0], stop)
`ifdef UART_TX_PARITY_EN
    frame_literal("b55", 8'h55, 11'b100_1010_1010);
`else
    frame_literal("b55", 8'h55, 11'b010_1010_1010);
`endif

    // 3: burst of 17 bytes with in_valid held high
    u_if.in_valid = 1'b1;
    idx = 0;
    guard = 0;
    u_if.in_data = 8'(idx);
    while (idx < 17 && guard < 200) begin
      @(posedge clk);
      acc = u_if.in_ready;
      @(negedge clk);
      guard++;
      if (acc) begin
        sent_q.push_back(8'(idx));
        idx++;
        u_if.in_data = 8'(idx);
      end
    end
    u_if.in_valid = 1'b0;
    check("burst_level_full", fifo_level, 16);
    check("burst_ready_low", u_if.in_ready, 0);
    wait_idle(18 * FRAME_CYC);
    compare_dec("burst");

    // 4: reset during DATA bit 3 of 0xA5 with three bytes queued
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    repeat (CLKDIV * 4 + CLKDIV / 2 - 2) @(negedge clk);
    check("midrst_line_bit3", ser_tx, 0);
    check("midrst_level", fifo_level, 3);
    #2 resetn = 1'b0;
    #1;
    check("midrst_ser_tx", ser_tx, 1);
    check("midrst_level0", fifo_level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", u_if.in_ready, 1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("midrst_no_frames", dec_q.size(), 0);
    check("midrst_idle", busy, 0);
    dec_q.delete();
    sent_q.delete();

    // 5: 40 random bytes at random in_valid duty, across pointer wraps
    idx = 0;
    guard = 0;
    max_level = 0;
    while (idx < 40 && guard < 60000) begin
      u_if.in_valid = ($urandom_range(0, 3) != 0);
      u_if.in_data  = 8'($urandom_range(0, 255));
      @(posedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      if (acc) begin
        sent_q.push_back(u_if.in_data);
        idx++;
      end
      @(negedge clk);
      guard++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    u_if.in_valid = 1'b0;
    check("wrap_all_sent", idx, 40);
    check("wrap_level_bounded", (max_level <= DEPTH) ? 1 : 0, 1);
    wait_idle(41 * FRAME_CYC);
    compare_dec("wrap");

`ifdef UART_TX_PARITY_EN
    // 6: even parity: 0x07 has three ones -> 1, 0x03 has two -> 0
    frame_literal("p07", 8'h07, 11'b110_0000_1110);
    frame_literal("p03", 8'h03, 11'b100_0000_0110);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
